// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable multi-channel clock divider.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } ch_state_e;

    localparam int unsigned DEFAULT_HALF = 5;

endpackage

// File: rtl/clk_div_if.sv
// Control and status bundle of the clock divider: per-channel enables, config writes, clocks and strobes.
interface clk_div_if #(
    parameter int unsigned NumCh    = 2,
    parameter int unsigned CntWidth = 16
);
    logic [NumCh-1:0]    en_i;
    logic [NumCh-1:0]    cfg_we_i;
    logic [CntWidth-1:0] cfg_half_i;
    logic                sync_i;
    logic [NumCh-1:0]    clk_o;
    logic [NumCh-1:0]    rise_o;
    logic [NumCh-1:0]    fall_o;
    logic [NumCh-1:0]    busy_o;
    logic [NumCh-1:0]    cfg_pending_o;

    modport master (
        output en_i, cfg_we_i, cfg_half_i, sync_i,
        input  clk_o, rise_o, fall_o, busy_o, cfg_pending_o
    );

    modport slave (
        input  en_i, cfg_we_i, cfg_half_i, sync_i,
        output clk_o, rise_o, fall_o, busy_o, cfg_pending_o
    );
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: IDLE/HIGH/LOW machine, half-period counter, shadow
// register and edge strobes. Ratio updates land only on entry into HIGH.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned CntWidth    = 16,
    parameter int unsigned DefaultHalf = DEFAULT_HALF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [CntWidth-1:0] half_i,
    input  logic                sync_i,
    output logic                clk_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic                busy_o,
    output logic                pend_o
);

    localparam logic [CntWidth-1:0] ONE      = CntWidth'(1);
    localparam logic [CntWidth-1:0] HALF_RST = CntWidth'(DefaultHalf);

    ch_state_e           state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] act_q, act_d;
    logic [CntWidth-1:0] shd_q, shd_d;
    logic                pend_q, pend_d;
    logic                clk_q, clk_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic                busy_q, busy_d;

    logic [CntWidth-1:0] wr_val;
    logic                last;
    logic                enter_hi;

    assign wr_val = (half_i == '0) ? ONE : half_i;
    assign last   = (cnt_q == (act_q - ONE));

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            act_q   <= HALF_RST;
            shd_q   <= HALF_RST;
            pend_q  <= 1'b0;
            clk_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            shd_q   <= shd_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: phase sequencing, sync realign, shadow write and apply
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        act_d    = act_q;
        shd_d    = shd_q;
        pend_d   = pend_q;
        enter_hi = 1'b0;

        if (we_i) begin
            shd_d  = wr_val;
            pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: enter_hi = en_i;
            HIGH: begin
                if (sync_i && en_i) begin
                    enter_hi = 1'b1;
                end else if (last) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            LOW: begin
                if (last) begin
                    cnt_d = '0;
                    if (en_i) enter_hi = 1'b1;
                    else      state_d  = IDLE;
                end else if (sync_i && en_i) begin
                    enter_hi = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A write in the same cycle as entry goes straight into the active ratio
        if (enter_hi) begin
            state_d = HIGH;
            cnt_d   = '0;
            pend_d  = 1'b0;
            if (we_i)        act_d = wr_val;
            else if (pend_q) act_d = shd_q;
        end
    end

    // Output decode from the upcoming state
    always_comb begin
        clk_d  = (state_d == HIGH);
        rise_d = clk_d & ~clk_q;
        fall_d = ~clk_d & clk_q;
        busy_d = (state_d != IDLE);
    end

    assign clk_o  = clk_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign busy_o = busy_q;
    assign pend_o = pend_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock generator: NumCh independent divider
// channels sharing the config bus and the global sync pulse.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int unsigned NumCh       = 2,
    parameter int unsigned CntWidth    = 16,
    parameter int unsigned DefaultHalf = DEFAULT_HALF
) (
    input  logic     clk_sys_in,
    input  logic     rst_sys_in,
    clk_div_if.slave bus
);

    logic [NumCh-1:0] clk_w;
    logic [NumCh-1:0] rise_w;
    logic [NumCh-1:0] fall_w;
    logic [NumCh-1:0] busy_w;
    logic [NumCh-1:0] pend_w;

    for (genvar c = 0; c < NumCh; c++) begin : g_ch
        clk_div_ch #(
            .CntWidth    (CntWidth),
            .DefaultHalf (DefaultHalf)
        ) u_ch (
            .clk    (clk_sys_in),
            .rst_n  (rst_sys_in),
            .en_i   (bus.en_i[c]),
            .we_i   (bus.cfg_we_i[c]),
            .half_i (bus.cfg_half_i),
            .sync_i (bus.sync_i),
            .clk_o  (clk_w[c]),
            .rise_o (rise_w[c]),
            .fall_o (fall_w[c]),
            .busy_o (busy_w[c]),
            .pend_o (pend_w[c])
        );
    end

    assign bus.clk_o         = clk_w;
    assign bus.rise_o        = rise_w;
    assign bus.fall_o        = fall_w;
    assign bus.busy_o        = busy_w;
    assign bus.cfg_pending_o = pend_w;

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: a cycle model pushes expected outputs per edge,
// popped and compared at the falling edge, plus directed period/phase checks.
module tb_clk_div_gen;

    localparam int unsigned NCH = 2;

    typedef struct packed {
        logic [NCH-1:0] clk;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
        logic [NCH-1:0] busy;
        logic [NCH-1:0] pend;
    } exp_t;

    logic clk;
    logic rst_n;

    clk_div_if #(.NumCh(NCH), .CntWidth(16)) bus ();

    clk_div_gen #(.NumCh(NCH), .CntWidth(16), .DefaultHalf(5)) dut (
        .clk_sys_in (clk),
        .rst_sys_in (rst_n),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    exp_t sb_q[$];

    // cycle model state: countdown of cycles left in the current phase
    bit m_on[NCH], m_hi[NCH], m_pend[NCH], m_clk[NCH];
    int m_left[NCH], m_act[NCH], m_shd[NCH];

    // measurements taken from observed DUT strobes
    int cyc = 0;
    int last_rise[NCH], period[NCH], hi_len[NCH], rise_cnt[NCH];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_on[c] = 0; m_hi[c] = 0; m_pend[c] = 0; m_clk[c] = 0;
            m_left[c] = 0; m_act[c] = 5; m_shd[c] = 5;
        end
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        exp_t e;
        e = '0;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int c = 0; c < NCH; c++) begin
                int  wv;
                bit  start, prev, en, we;
                wv    = (bus.cfg_half_i == 16'd0) ? 1 : int'(bus.cfg_half_i);
                en    = bus.en_i[c];
                we    = bus.cfg_we_i[c];
                prev  = m_clk[c];
                start = 0;
                if (!m_on[c]) begin
                    start = en;
                end else if (m_hi[c]) begin
                    if (bus.sync_i && en) start = 1;
                    else if (m_left[c] == 1) begin m_hi[c] = 0; m_left[c] = m_act[c]; end
                    else m_left[c]--;
                end else begin
                    if (m_left[c] == 1) begin
                        if (en) start = 1; else m_on[c] = 0;
                    end else if (bus.sync_i && en) start = 1;
                    else m_left[c]--;
                end
                if (start) begin
                    if (we) m_act[c] = wv;
                    else if (m_pend[c]) m_act[c] = m_shd[c];
                    if (we) m_shd[c] = wv;
                    m_pend[c] = 0;
                    m_on[c] = 1; m_hi[c] = 1; m_left[c] = m_act[c];
                end else if (we) begin
                    m_shd[c] = wv; m_pend[c] = 1;
                end
                m_clk[c]  = m_on[c] && m_hi[c];
                e.clk[c]  = m_clk[c];
                e.rise[c] = m_clk[c] && !prev;
                e.fall[c] = !m_clk[c] && prev;
                e.busy[c] = m_on[c];
                e.pend[c] = m_pend[c];
            end
        end
        sb_q.push_back(e);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock, compare the scoreboard entry, update measurements
    task automatic tick();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 16'd0, 16'd1);
        end else begin
            e = sb_q.pop_front();
            chk("clk_o",         16'(bus.clk_o),         16'(e.clk));
            chk("rise_o",        16'(bus.rise_o),        16'(e.rise));
            chk("fall_o",        16'(bus.fall_o),        16'(e.fall));
            chk("busy_o",        16'(bus.busy_o),        16'(e.busy));
            chk("cfg_pending_o", 16'(bus.cfg_pending_o), 16'(e.pend));
        end
        for (int c = 0; c < NCH; c++) begin
            if (bus.rise_o[c] === 1'b1) begin
                if (last_rise[c] >= 0) period[c] = cyc - last_rise[c];
                last_rise[c] = cyc;
                rise_cnt[c]++;
            end
            if (bus.fall_o[c] === 1'b1) hi_len[c] = cyc - last_rise[c];
        end
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_clk"},  16'(bus.clk_o),         16'd0);
        chk({tag, "_rise"}, 16'(bus.rise_o),        16'd0);
        chk({tag, "_fall"}, 16'(bus.fall_o),        16'd0);
        chk({tag, "_busy"}, 16'(bus.busy_o),        16'd0);
        chk({tag, "_pend"}, 16'(bus.cfg_pending_o), 16'd0);
    endtask

    initial begin
        int n;
        int snap;
        for (int c = 0; c < NCH; c++) begin
            last_rise[c] = -1; period[c] = 0; hi_len[c] = 0; rise_cnt[c] = 0;
        end
        rst_n          = 1'b0;
        bus.en_i       = '0;
        bus.cfg_we_i   = '0;
        bus.cfg_half_i = '0;
        bus.sync_i     = 1'b0;
        #1;
        chk_all_zero("reset");
        ticks(2);

        // Default divide-by-10 from reset release
        bus.en_i = 2'b01;
        rst_n    = 1'b1;
        tick();
        chk("first_rise", 16'(bus.rise_o[0]), 16'd1);
        ticks(24);
        chk("dflt_hi", 16'(hi_len[0]), 16'd5);
        chk("dflt_per", 16'(period[0]), 16'd10);

        // Write 3 mid HIGH phase: current period completes at 5+5
        n = 0;
        while (bus.rise_o[0] !== 1'b1 && n < 20) begin tick(); n++; end
        chk("wait_rise0", 16'(bus.rise_o[0]), 16'd1);
        ticks(2);
        bus.cfg_we_i = 2'b01; bus.cfg_half_i = 16'd3;
        tick();
        bus.cfg_we_i = 2'b00;
        chk("pend_set", 16'(bus.cfg_pending_o[0]), 16'd1);
        n = 0;
        while (bus.rise_o[0] !== 1'b1 && n < 20) begin tick(); n++; end
        chk("pend_clr", 16'(bus.cfg_pending_o[0]), 16'd0);
        chk("old_per", 16'(period[0]), 16'd10);
        ticks(14);
        chk("new_hi", 16'(hi_len[0]), 16'd3);
        chk("new_per", 16'(period[0]), 16'd6);

        // Channel 1: start with act=4, drop enable one cycle into HIGH
        bus.cfg_we_i = 2'b10; bus.cfg_half_i = 16'd4; bus.en_i = 2'b11;
        tick();
        bus.cfg_we_i = 2'b00; bus.en_i = 2'b01;
        chk("wt_nopend", 16'(bus.cfg_pending_o[1]), 16'd0);
        tick();
        snap = rise_cnt[1];
        ticks(10);
        chk("stop_hi", 16'(hi_len[1]), 16'd4);
        chk("stop_busy", 16'(bus.busy_o[1]), 16'd0);
        chk("stop_norise", 16'(rise_cnt[1]), 16'(snap));

        // Half-period 0 behaves as 1: divide-by-2
        bus.cfg_we_i = 2'b10; bus.cfg_half_i = 16'd0; bus.en_i = 2'b11;
        tick();
        bus.cfg_we_i = 2'b00;
        ticks(8);
        chk("div2_per", 16'(period[1]), 16'd2);
        chk("div2_hi", 16'(hi_len[1]), 16'd1);

        // Channel 1 to act=5, then sync both channels while both are low
        bus.cfg_we_i = 2'b10; bus.cfg_half_i = 16'd5;
        tick();
        bus.cfg_we_i = 2'b00;
        ticks(4);
        n = 0;
        while (bus.clk_o !== 2'b00 && n < 40) begin tick(); n++; end
        chk("wait_both_low", 16'(bus.clk_o), 16'd0);
        bus.sync_i = 1'b1;
        tick();
        bus.sync_i = 1'b0;
        chk("sync_rise", 16'(bus.rise_o), 16'd3);
        chk("sync_align", 16'(last_rise[1]), 16'(last_rise[0]));
        ticks(30);
        chk("sync_per0", 16'(period[0]), 16'd6);
        chk("sync_per1", 16'(period[1]), 16'd10);

        // Reset mid LOW with a pending write: discarded, back to act=5
        n = 0;
        while (bus.fall_o[0] !== 1'b1 && n < 20) begin tick(); n++; end
        chk("wait_fall0", 16'(bus.fall_o[0]), 16'd1);
        bus.cfg_we_i = 2'b01; bus.cfg_half_i = 16'd7;
        tick();
        bus.cfg_we_i = 2'b00;
        chk("pend_before_rst", 16'(bus.cfg_pending_o[0]), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_rise", 16'(bus.rise_o[0]), 16'd1);
        ticks(24);
        chk("rst_hi", 16'(hi_len[0]), 16'd5);
        chk("rst_per", 16'(period[0]), 16'd10);
        chk("rst_pend", 16'(bus.cfg_pending_o[0]), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
